// File: rtl/card_datapath.sv
// card_datapath: datapath responder for the baccarat hand controller.
// A free-running card generator (SEED..DECK_MAX, wrapping to 1) is captured
// into the strobed player/dealer card registers. Scores (sum of card values
// mod 10) are combinational from those registers.
//
// Ports:
//   slow_clock, resetb            clock, asynchronous active-low reset
//   load_pcard1..3, load_dcard1..3 capture strobes
//   pcard1..3, dcard1..3          card codes (0 = empty, 1..13 = A..K)
//   pscore, dscore                combinational scores 0..9
//   new_card                      current generator value
//   cards_dealt                   capture count, saturating at 6
//   load_conflict                 one-cycle pulse after a multi-strobe edge
//
// Optional: define CARD_DATAPATH_TALLY_EN to add player_win_light,
// dealer_win_light inputs and player_wins, dealer_wins saturating tallies.
module card_datapath #(
    parameter int unsigned SEED     = 1,
    parameter int unsigned DECK_MAX = 13
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       load_pcard1,
    input  logic       load_pcard2,
    input  logic       load_pcard3,
    input  logic       load_dcard1,
    input  logic       load_dcard2,
    input  logic       load_dcard3,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic [3:0] new_card,
    output logic [2:0] cards_dealt,
    output logic       load_conflict
`ifdef CARD_DATAPATH_TALLY_EN
    ,
    input  logic       player_win_light,
    input  logic       dealer_win_light,
    output logic [3:0] player_wins,
    output logic [3:0] dealer_wins
`endif
);

    localparam int unsigned CARD_W = 4;
    localparam int unsigned SUM_W  = 5;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned MAX_DEALT = 6;

    // Baccarat value of a card code: 1..9 face value, tens/faces/empty are 0.
    function automatic logic [SUM_W-1:0] card_val(input logic [CARD_W-1:0] c);
        return ((c >= CARD_W'(1)) && (c <= CARD_W'(9))) ? SUM_W'(c) : '0;
    endfunction

    logic [CNT_W-1:0] strobe_cnt;
    logic [CNT_W:0]   dealt_sum;
    logic [SUM_W-1:0] psum;
    logic [SUM_W-1:0] dsum;

    // Number of strobes asserted on this edge.
    assign strobe_cnt = CNT_W'(load_pcard1) + CNT_W'(load_pcard2) + CNT_W'(load_pcard3)
                      + CNT_W'(load_dcard1) + CNT_W'(load_dcard2) + CNT_W'(load_dcard3);
    assign dealt_sum  = (CNT_W+1)'(cards_dealt) + (CNT_W+1)'(strobe_cnt);

    // Scores: max sum is 27, so 5 bits suffice before the mod.
    assign psum   = card_val(pcard1) + card_val(pcard2) + card_val(pcard3);
    assign dsum   = card_val(dcard1) + card_val(dcard2) + card_val(dcard3);
    assign pscore = CARD_W'(psum % SUM_W'(10));
    assign dscore = CARD_W'(dsum % SUM_W'(10));

    // Free-running generator; never pauses, never holds 0.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            new_card <= CARD_W'(SEED);
        end else if (new_card == CARD_W'(DECK_MAX)) begin
            new_card <= CARD_W'(1);
        end else begin
            new_card <= new_card + CARD_W'(1);
        end
    end

    // Card capture; simultaneous strobes all take the same pre-edge value.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pcard1 <= '0;
            pcard2 <= '0;
            pcard3 <= '0;
            dcard1 <= '0;
            dcard2 <= '0;
            dcard3 <= '0;
        end else begin
            if (load_pcard1) pcard1 <= new_card;
            if (load_pcard2) pcard2 <= new_card;
            if (load_pcard3) pcard3 <= new_card;
            if (load_dcard1) dcard1 <= new_card;
            if (load_dcard2) dcard2 <= new_card;
            if (load_dcard3) dcard3 <= new_card;
        end
    end

    // Dealt counter (saturating) and conflict pulse.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            cards_dealt   <= '0;
            load_conflict <= 1'b0;
        end else begin
            cards_dealt   <= (dealt_sum > (CNT_W+1)'(MAX_DEALT)) ? CNT_W'(MAX_DEALT)
                                                                 : dealt_sum[CNT_W-1:0];
            load_conflict <= (strobe_cnt > CNT_W'(1));
        end
    end

`ifdef CARD_DATAPATH_TALLY_EN
    logic pw_q, pw_d, dw_q, dw_d;
    logic p_rise, d_rise;

    assign p_rise = pw_q & ~pw_d;
    assign d_rise = dw_q & ~dw_d;

    // Registered win lights with rising-edge tally; a tie counts for nobody.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pw_q        <= 1'b0;
            pw_d        <= 1'b0;
            dw_q        <= 1'b0;
            dw_d        <= 1'b0;
            player_wins <= '0;
            dealer_wins <= '0;
        end else begin
            pw_q <= player_win_light;
            pw_d <= pw_q;
            dw_q <= dealer_win_light;
            dw_d <= dw_q;
            if (p_rise && !d_rise && (player_wins != 4'hF)) player_wins <= player_wins + 4'd1;
            if (d_rise && !p_rise && (dealer_wins != 4'hF)) dealer_wins <= dealer_wins + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_card_datapath.sv
// Self-checking bench for card_datapath against a behavioural hand model.
module tb_card_datapath;

    logic       slow_clock = 1'b0;
    logic       resetb;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore, new_card;
    logic [2:0] cards_dealt;
    logic       load_conflict;
`ifdef CARD_DATAPATH_TALLY_EN
    logic       player_win_light, dealer_win_light;
    logic [3:0] player_wins, dealer_wins;
    int         m_pw, m_dw;
    bit         m_lp, m_ld;
`endif

    int checks = 0;
    int errors = 0;

    // Model of the hand: card arrays, generator, count, conflict flag.
    int m_pc[3];
    int m_dc[3];
    int m_gen;
    int m_dealt;
    bit m_conf;

    card_datapath dut (
        .slow_clock    (slow_clock),
        .resetb        (resetb),
        .load_pcard1   (load_pcard1),
        .load_pcard2   (load_pcard2),
        .load_pcard3   (load_pcard3),
        .load_dcard1   (load_dcard1),
        .load_dcard2   (load_dcard2),
        .load_dcard3   (load_dcard3),
        .pcard1        (pcard1),
        .pcard2        (pcard2),
        .pcard3        (pcard3),
        .dcard1        (dcard1),
        .dcard2        (dcard2),
        .dcard3        (dcard3),
        .pscore        (pscore),
        .dscore        (dscore),
        .new_card      (new_card),
        .cards_dealt   (cards_dealt),
        .load_conflict (load_conflict)
`ifdef CARD_DATAPATH_TALLY_EN
        ,
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
        .player_wins      (player_wins),
        .dealer_wins      (dealer_wins)
`endif
    );

    always #5 slow_clock = ~slow_clock;

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic int score(input int a, input int b, input int c);
        return (val(a) + val(b) + val(c)) % 10;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            m_pc[i] = 0;
            m_dc[i] = 0;
        end
        m_gen   = 1;
        m_dealt = 0;
        m_conf  = 0;
`ifdef CARD_DATAPATH_TALLY_EN
        m_pw = 0;
        m_dw = 0;
        m_lp = 0;
        m_ld = 0;
`endif
    endfunction

    // One clock edge with strobe mask ld = {d3,d2,d1,p3,p2,p1}.
    task automatic step(input logic [5:0] ld);
        int n;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
        @(posedge slow_clock);
        #1;
        n = $countones(ld);
        for (int i = 0; i < 3; i++) begin
            if (ld[i])     m_pc[i] = m_gen;
            if (ld[i + 3]) m_dc[i] = m_gen;
        end
        m_conf  = (n > 1);
        m_dealt = (m_dealt + n > 6) ? 6 : m_dealt + n;
        m_gen   = (m_gen == 13) ? 1 : m_gen + 1;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = '0;
    endtask

    task automatic do_reset();
        resetb = 1'b0;
        #2;
        model_reset();
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask

    // Idle until the model's generator shows the wanted code (bounded).
    task automatic wait_card(input int code);
        for (int i = 0; i < 14 && m_gen != code; i++) step(6'b0);
    endtask

    task automatic test_reset();
        step(6'b001001);
        step(6'b000010);
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({pcard1, pcard2, pcard3, dcard1, dcard2, dcard3} !== 24'h0) begin
            errors++;
            $display("FAIL reset_cards got %h exp 0", {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3});
        end
        checks++;
        if (pscore !== 4'd0 || dscore !== 4'd0) begin
            errors++;
            $display("FAIL reset_scores got %0d/%0d exp 0/0", pscore, dscore);
        end
        checks++;
        if (new_card !== 4'd1) begin
            errors++;
            $display("FAIL reset_new_card got %0d exp 1", new_card);
        end
        checks++;
        if (cards_dealt !== 3'd0 || load_conflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_dealt got %0d/%0b exp 0/0", cards_dealt, load_conflict);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        step(6'b0);
        checks++;
        if (new_card !== 4'd2) begin
            errors++;
            $display("FAIL gen_edge1 got %0d exp 2", new_card);
        end
        for (int i = 0; i < 11; i++) step(6'b0);
        checks++;
        if (new_card !== 4'd13) begin
            errors++;
            $display("FAIL gen_edge12 got %0d exp 13", new_card);
        end
    endtask

    task automatic test_wrap();
        step(6'b0);
        checks++;
        if (new_card !== 4'd1) begin
            errors++;
            $display("FAIL wrap_to_1 got %0d exp 1", new_card);
        end
        step(6'b0);
        checks++;
        if (new_card !== 4'd2) begin
            errors++;
            $display("FAIL wrap_then_2 got %0d exp 2", new_card);
        end
    endtask

    task automatic test_player_hand();
        do_reset();
        step(6'b000001);
        step(6'b0);
        step(6'b0);
        step(6'b000010);
        checks++;
        if (pcard1 !== 4'd1 || pcard2 !== 4'd4) begin
            errors++;
            $display("FAIL hand_cards got %0d,%0d exp 1,4", pcard1, pcard2);
        end
        checks++;
        if (pscore !== 4'(score(m_pc[0], m_pc[1], m_pc[2])) || pscore !== 4'd5) begin
            errors++;
            $display("FAIL hand_pscore got %0d exp 5", pscore);
        end
        checks++;
        if (cards_dealt !== 3'd2 || pcard3 !== 4'd0) begin
            errors++;
            $display("FAIL hand_dealt got %0d pcard3 %0d exp 2,0", cards_dealt, pcard3);
        end
    endtask

    task automatic test_face_mod();
        do_reset();
        wait_card(12); step(6'b000001);
        wait_card(13); step(6'b000010);
        checks++;
        if (pcard1 !== 4'd12 || pcard2 !== 4'd13 || pscore !== 4'd0) begin
            errors++;
            $display("FAIL face_score got %0d,%0d score %0d exp 12,13 score 0", pcard1, pcard2, pscore);
        end
        do_reset();
        wait_card(7); step(6'b000100);
        wait_card(8); step(6'b000010);
        wait_card(9); step(6'b000001);
        checks++;
        if (pscore !== 4'd4 || pscore !== 4'(score(m_pc[0], m_pc[1], m_pc[2]))) begin
            errors++;
            $display("FAIL mod_score got %0d exp 4", pscore);
        end
        do_reset();
        wait_card(5);  step(6'b010000);
        wait_card(10); step(6'b001000);
        checks++;
        if (dcard1 !== 4'd10 || dcard2 !== 4'd5 || dscore !== 4'd5) begin
            errors++;
            $display("FAIL ten_score got %0d,%0d score %0d exp 10,5 score 5", dcard1, dcard2, dscore);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        wait_card(7);
        step(6'b001001);
        checks++;
        if (pcard1 !== 4'd7 || dcard1 !== 4'd7 || dscore !== 4'd7) begin
            errors++;
            $display("FAIL conflict_cards got %0d,%0d dscore %0d exp 7,7,7", pcard1, dcard1, dscore);
        end
        checks++;
        if (load_conflict !== 1'b1 || cards_dealt !== 3'd2) begin
            errors++;
            $display("FAIL conflict_pulse got %0b dealt %0d exp 1,2", load_conflict, cards_dealt);
        end
        step(6'b0);
        checks++;
        if (load_conflict !== 1'b0) begin
            errors++;
            $display("FAIL conflict_clear got %0b exp 0", load_conflict);
        end
        step(6'b010010);
        step(6'b100100);
        step(6'b000110);
        checks++;
        if (cards_dealt !== 3'd6 || load_conflict !== 1'b1) begin
            errors++;
            $display("FAIL dealt_saturate got %0d conflict %0b exp 6,1", cards_dealt, load_conflict);
        end
    endtask

    // Random strobes; every output compared with the model each edge.
    task automatic test_random();
        logic [5:0] ld;
        logic [3:0] gp[3];
        logic [3:0] gd[3];
        do_reset();
        for (int n = 0; n < 300; n++) begin
            for (int b = 0; b < 6; b++) ld[b] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0) do_reset();
            step(ld);
            gp = '{pcard1, pcard2, pcard3};
            gd = '{dcard1, dcard2, dcard3};
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gp[i] !== 4'(m_pc[i]) || gd[i] !== 4'(m_dc[i])) begin
                    errors++;
                    $display("FAIL rnd_card%0d step %0d got p%0d d%0d exp p%0d d%0d",
                             i + 1, n, gp[i], gd[i], m_pc[i], m_dc[i]);
                end
            end
            checks++;
            if (pscore !== 4'(score(m_pc[0], m_pc[1], m_pc[2])) ||
                dscore !== 4'(score(m_dc[0], m_dc[1], m_dc[2]))) begin
                errors++;
                $display("FAIL rnd_score step %0d got %0d/%0d exp %0d/%0d", n, pscore, dscore,
                         score(m_pc[0], m_pc[1], m_pc[2]), score(m_dc[0], m_dc[1], m_dc[2]));
            end
            checks++;
            if (new_card !== 4'(m_gen) || new_card === 4'd0) begin
                errors++;
                $display("FAIL rnd_new_card step %0d got %0d exp %0d", n, new_card, m_gen);
            end
            checks++;
            if (cards_dealt !== 3'(m_dealt) || load_conflict !== m_conf) begin
                errors++;
                $display("FAIL rnd_dealt step %0d got %0d/%0b exp %0d/%0b",
                         n, cards_dealt, load_conflict, m_dealt, m_conf);
            end
        end
    endtask

`ifdef CARD_DATAPATH_TALLY_EN
    // Drive the lights for one edge; the model counts rising samples.
    task automatic light_step(input bit p, input bit d);
        bit rp, rd;
        player_win_light = p;
        dealer_win_light = d;
        step(6'b0);
        rp = p && !m_lp;
        rd = d && !m_ld;
        if (rp && !rd && m_pw < 15) m_pw++;
        if (rd && !rp && m_dw < 15) m_dw++;
        m_lp = p;
        m_ld = d;
    endtask

    task automatic test_tally();
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) light_step(1, 0);
        light_step(0, 0);
        light_step(0, 0);
        checks++;
        if (player_wins !== 4'd1 || player_wins !== 4'(m_pw) || dealer_wins !== 4'd0) begin
            errors++;
            $display("FAIL tally_player got %0d/%0d exp 1/0", player_wins, dealer_wins);
        end
        light_step(1, 1);
        light_step(1, 1);
        light_step(0, 0);
        light_step(0, 0);
        checks++;
        if (player_wins !== 4'd1 || dealer_wins !== 4'd0) begin
            errors++;
            $display("FAIL tally_tie got %0d/%0d exp 1/0", player_wins, dealer_wins);
        end
        light_step(0, 1);
        light_step(0, 0);
        light_step(0, 0);
        checks++;
        if (dealer_wins !== 4'd1 || dealer_wins !== 4'(m_dw)) begin
            errors++;
            $display("FAIL tally_dealer got %0d exp 1", dealer_wins);
        end
        for (int i = 0; i < 16; i++) begin
            light_step(1, 0);
            light_step(0, 0);
        end
        light_step(0, 0);
        checks++;
        if (player_wins !== 4'd15 || player_wins !== 4'(m_pw)) begin
            errors++;
            $display("FAIL tally_saturate got %0d exp 15", player_wins);
        end
        resetb = 1'b0;
        #1;
        checks++;
        if (player_wins !== 4'd0 || dealer_wins !== 4'd0) begin
            errors++;
            $display("FAIL tally_reset got %0d/%0d exp 0/0", player_wins, dealer_wins);
        end
        model_reset();
        @(negedge slow_clock);
        resetb = 1'b1;
    endtask
`endif

    initial begin
        resetb = 1'b0;
        {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = '0;
`ifdef CARD_DATAPATH_TALLY_EN
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge slow_clock);
        resetb = 1'b1;
        test_reset();
        test_wrap();
        test_player_hand();
        test_face_mod();
        test_conflict();
        test_random();
`ifdef CARD_DATAPATH_TALLY_EN
        test_tally();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
